// File: rtl/tlul_host_adapter.sv
// Host-side TL-UL bridge: req/gnt/rvalid master port to tl_h2d_t/tl_d2h_t, in-order responses.
// Optional d_source check against the expected-source FIFO: define TLUL_HOST_SRC_CHECK_EN.

package tlul_pkg;

   typedef enum logic [2:0] {
      PutFullData    = 3'h0,
      PutPartialData = 3'h1,
      Get            = 3'h4
   } tl_a_op_e;

   typedef enum logic [2:0] {
      AccessAck     = 3'h0,
      AccessAckData = 3'h1
   } tl_d_op_e;

   typedef struct packed {
      logic [3:0] instr_type;
      logic [6:0] cmd_intg;
      logic [6:0] data_intg;
   } tl_a_user_t;

   parameter tl_a_user_t TL_A_USER_DEFAULT = '{instr_type: 4'b1001, cmd_intg: 7'h0, data_intg: 7'h0};

   typedef struct packed {
      logic [6:0] rsp_intg;
      logic [6:0] data_intg;
   } tl_d_user_t;

   typedef struct packed {
      logic        a_valid;
      tl_a_op_e    a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      tl_a_user_t  a_user;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      tl_d_op_e    d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic [0:0]  d_sink;
      logic [31:0] d_data;
      tl_d_user_t  d_user;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

endpackage

module tlul_host_adapter #(
   parameter int Outstanding = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             req_i,
   output logic             gnt_o,
   input  logic [31:0]      addr_i,
   input  logic             we_i,
   input  logic [31:0]      wdata_i,
   input  logic [3:0]       be_i,
   output logic             rvalid_o,
   output logic [31:0]      rdata_o,
   output logic             err_o,
   output logic             unexp_rsp_o,
   output tlul_pkg::tl_h2d_t tl_o,
   input  tlul_pkg::tl_d2h_t tl_i
);

   localparam logic [2:0] MaxCnt  = 3'(Outstanding);
   localparam logic [1:0] LastSrc = 2'(Outstanding - 1);

   logic [2:0] cnt_q, cnt_d;
   logic [1:0] src_q, src_d;
   logic       unexp_q, unexp_d;
   logic       a_valid;
   logic       a_hs;
   logic       d_beat;
   logic       d_acc;
   logic       src_mismatch;

   // d_ready is tied high, so every d_valid is a consumed beat.
   assign a_valid = req_i & (cnt_q < MaxCnt);
   assign a_hs    = a_valid & tl_i.a_ready;
   assign d_beat  = tl_i.d_valid;
   assign d_acc   = d_beat & (cnt_q != 3'd0);

   always_comb begin
      cnt_d = cnt_q;
      unique case ({a_hs, d_acc})
         2'b10:   cnt_d = cnt_q + 3'd1;
         2'b01:   cnt_d = cnt_q - 3'd1;
         default: cnt_d = cnt_q;
      endcase
      src_d = src_q;
      if (a_hs) begin
         src_d = (src_q == LastSrc) ? 2'd0 : src_q + 2'd1;
      end
      unexp_d = d_beat & (cnt_q == 3'd0);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q   <= 3'd0;
         src_q   <= 2'd0;
         unexp_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         src_q   <= src_d;
         unexp_q <= unexp_d;
      end
   end

`ifdef TLUL_HOST_SRC_CHECK_EN
   // The write slot always equals src_q since both advance on the A handshake and wrap alike.
   logic [1:0] exp_q [4];
   logic [1:0] rptr_q, rptr_d;

   always_comb begin
      rptr_d = rptr_q;
      if (d_acc) begin
         rptr_d = (rptr_q == LastSrc) ? 2'd0 : rptr_q + 2'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 4; i++) exp_q[i] <= 2'd0;
         rptr_q <= 2'd0;
      end else begin
         if (a_hs) exp_q[src_q] <= src_q;
         rptr_q <= rptr_d;
      end
   end

   assign src_mismatch = (tl_i.d_source != {6'b0, exp_q[rptr_q]});

   logic unused_tl;
   assign unused_tl = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user, addr_i[1:0]};
`else
   assign src_mismatch = 1'b0;

   logic unused_tl;
   assign unused_tl = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user, tl_i.d_source,
                        addr_i[1:0]};
`endif

   always_comb begin
      tl_o           = '0;
      tl_o.a_valid   = a_valid;
      tl_o.a_opcode  = !we_i          ? tlul_pkg::Get :
                       (be_i == 4'hF) ? tlul_pkg::PutFullData : tlul_pkg::PutPartialData;
      tl_o.a_param   = 3'd0;
      tl_o.a_size    = 2'd2;
      tl_o.a_source  = {6'b0, src_q};
      tl_o.a_address = {addr_i[31:2], 2'b00};
      tl_o.a_mask    = we_i ? be_i : 4'hF;
      tl_o.a_data    = we_i ? wdata_i : 32'h0;
      tl_o.a_user    = tlul_pkg::TL_A_USER_DEFAULT;
      tl_o.d_ready   = 1'b1;
   end

   assign gnt_o       = a_hs;
   assign rvalid_o    = d_acc;
   assign rdata_o     = (d_acc && tl_i.d_opcode == tlul_pkg::AccessAckData) ? tl_i.d_data : 32'h0;
   assign err_o       = d_acc & (tl_i.d_error | src_mismatch);
   assign unexp_rsp_o = unexp_q;

endmodule

// File: tb/tb_tlul_host_adapter.sv
// Directed bench for tlul_host_adapter (Outstanding=2): grants, responses, backpressure, unexpected beats, reset.
module tb_tlul_host_adapter;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req;
   logic              gnt;
   logic [31:0]       addr;
   logic              we;
   logic [31:0]       wdata;
   logic [3:0]        be;
   logic              rvalid;
   logic [31:0]       rdata;
   logic              err;
   logic              unexp;
   tlul_pkg::tl_h2d_t tl_h2d;
   tlul_pkg::tl_d2h_t tl_d2h;

   int checks   = 0;
   int failures = 0;

   tlul_host_adapter #(.Outstanding(2)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_i       (req),
      .gnt_o       (gnt),
      .addr_i      (addr),
      .we_i        (we),
      .wdata_i     (wdata),
      .be_i        (be),
      .rvalid_o    (rvalid),
      .rdata_o     (rdata),
      .err_o       (err),
      .unexp_rsp_o (unexp),
      .tl_o        (tl_h2d),
      .tl_i        (tl_d2h)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic drive_req(input logic r, input logic w, input logic [31:0] a,
                            input logic [3:0] b, input logic [31:0] wd);
      req = r; we = w; addr = a; be = b; wdata = wd;
   endtask

   task automatic drive_d(input logic v, input logic [2:0] op, input logic [7:0] src,
                          input logic [31:0] data, input logic e);
      tl_d2h.d_valid  = v;
      tl_d2h.d_opcode = tlul_pkg::tl_d_op_e'(op);
      tl_d2h.d_source = src;
      tl_d2h.d_data   = data;
      tl_d2h.d_error  = e;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".gnt"},     32'(gnt), 32'd0);
      chk({tag, ".rvalid"},  32'(rvalid), 32'd0);
      chk({tag, ".rdata"},   rdata, 32'd0);
      chk({tag, ".err"},     32'(err), 32'd0);
      chk({tag, ".unexp"},   32'(unexp), 32'd0);
      chk({tag, ".a_valid"}, 32'(tl_h2d.a_valid), 32'd0);
      chk({tag, ".d_ready"}, 32'(tl_h2d.d_ready), 32'd1);
   endtask

   initial begin
      rst_n  = 1'b0;
      tl_d2h = '0;
      tl_d2h.a_ready = 1'b1;
      drive_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      drive_d(1'b0, 3'd0, 8'd0, 32'h0, 1'b0);

      // Reset state
      @(negedge clk); #1;
      chk_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Single read
      @(negedge clk);
      drive_req(1'b1, 1'b0, 32'h2000_0006, 4'h0, 32'h0);
      #1;
      chk("rd.a_valid", 32'(tl_h2d.a_valid), 32'd1);
      chk("rd.gnt",     32'(gnt), 32'd1);
      chk("rd.opcode",  32'(tl_h2d.a_opcode), 32'd4);
      chk("rd.address", tl_h2d.a_address, 32'h2000_0004);
      chk("rd.mask",    32'(tl_h2d.a_mask), 32'hF);
      chk("rd.source",  32'(tl_h2d.a_source), 32'd0);
      chk("rd.data",    tl_h2d.a_data, 32'h0);
      chk("rd.size",    32'(tl_h2d.a_size), 32'd2);
      @(negedge clk);
      drive_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      drive_d(1'b1, 3'd1, 8'd0, 32'hDEAD_BEEF, 1'b0);
      #1;
      chk("rd.rvalid", 32'(rvalid), 32'd1);
      chk("rd.rdata",  rdata, 32'hDEAD_BEEF);
      chk("rd.err",    32'(err), 32'd0);

      // Partial write, error response
      @(negedge clk);
      drive_d(1'b0, 3'd0, 8'd0, 32'h0, 1'b0);
      drive_req(1'b1, 1'b1, 32'h0000_0100, 4'b0011, 32'h1234_5678);
      #1;
      chk("pw.gnt",    32'(gnt), 32'd1);
      chk("pw.opcode", 32'(tl_h2d.a_opcode), 32'd1);
      chk("pw.mask",   32'(tl_h2d.a_mask), 32'h3);
      chk("pw.data",   tl_h2d.a_data, 32'h1234_5678);
      chk("pw.source", 32'(tl_h2d.a_source), 32'd1);
      @(negedge clk);
      drive_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      drive_d(1'b1, 3'd0, 8'd1, 32'hFFFF_FFFF, 1'b1);
      #1;
      chk("pw.rvalid", 32'(rvalid), 32'd1);
      chk("pw.rdata",  rdata, 32'h0);
      chk("pw.err",    32'(err), 32'd1);

      // Backpressure: two grants then full
      @(negedge clk);
      drive_d(1'b0, 3'd0, 8'd0, 32'h0, 1'b0);
      drive_req(1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0);
      #1;
      chk("bp1.gnt",    32'(gnt), 32'd1);
      chk("bp1.source", 32'(tl_h2d.a_source), 32'd0);
      @(negedge clk);
      drive_req(1'b1, 1'b1, 32'h0000_0014, 4'hF, 32'hCAFE_0001);
      #1;
      chk("bp2.gnt",    32'(gnt), 32'd1);
      chk("bp2.source", 32'(tl_h2d.a_source), 32'd1);
      chk("bp2.opcode", 32'(tl_h2d.a_opcode), 32'd0);
      @(negedge clk);
      drive_req(1'b1, 1'b0, 32'h0000_0018, 4'h0, 32'h0);
      #1;
      chk("bp3.a_valid", 32'(tl_h2d.a_valid), 32'd0);
      chk("bp3.gnt",     32'(gnt), 32'd0);
      @(negedge clk);
      drive_d(1'b1, 3'd1, 8'd0, 32'h1111_1111, 1'b0);
      #1;
      chk("bp_beat.a_valid", 32'(tl_h2d.a_valid), 32'd0);
      chk("bp_beat.rvalid",  32'(rvalid), 32'd1);
      chk("bp_beat.rdata",   rdata, 32'h1111_1111);
      @(negedge clk);
      drive_d(1'b0, 3'd0, 8'd0, 32'h0, 1'b0);
      #1;
      chk("bp_next.a_valid", 32'(tl_h2d.a_valid), 32'd1);
      chk("bp_next.gnt",     32'(gnt), 32'd1);
      chk("bp_next.source",  32'(tl_h2d.a_source), 32'd0);

      // Drain one (full write -> AccessAck), then grant and beat in the same cycle
      @(negedge clk);
      drive_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      drive_d(1'b1, 3'd0, 8'd1, 32'h5555_5555, 1'b0);
      #1;
      chk("drain.rvalid", 32'(rvalid), 32'd1);
      chk("drain.rdata",  rdata, 32'h0);
      chk("drain.err",    32'(err), 32'd0);
      @(negedge clk);
      drive_req(1'b1, 1'b0, 32'h0000_0020, 4'h0, 32'h0);
      drive_d(1'b1, 3'd1, 8'd0, 32'h2222_2222, 1'b0);
      #1;
      chk("sim.gnt",    32'(gnt), 32'd1);
      chk("sim.source", 32'(tl_h2d.a_source), 32'd1);
      chk("sim.rvalid", 32'(rvalid), 32'd1);
      chk("sim.rdata",  rdata, 32'h2222_2222);
      @(negedge clk);
      drive_d(1'b0, 3'd0, 8'd0, 32'h0, 1'b0);
      drive_req(1'b1, 1'b0, 32'h0000_0024, 4'h0, 32'h0);
      #1;
      chk("sim2.gnt",    32'(gnt), 32'd1);
      chk("sim2.source", 32'(tl_h2d.a_source), 32'd0);
      @(negedge clk);
      #1;
      chk("sim_full.a_valid", 32'(tl_h2d.a_valid), 32'd0);
      @(negedge clk);
      drive_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      drive_d(1'b1, 3'd1, 8'd1, 32'h3333_3333, 1'b0);
      #1;
      chk("ord1.rvalid", 32'(rvalid), 32'd1);
      chk("ord1.rdata",  rdata, 32'h3333_3333);
      chk("ord1.err",    32'(err), 32'd0);
      @(negedge clk);
      drive_d(1'b1, 3'd1, 8'd0, 32'h4444_4444, 1'b0);
      #1;
      chk("ord2.rvalid", 32'(rvalid), 32'd1);
      chk("ord2.rdata",  rdata, 32'h4444_4444);
      chk("ord2.err",    32'(err), 32'd0);

      // Unexpected beat with nothing outstanding
      @(negedge clk);
      drive_d(1'b1, 3'd1, 8'd0, 32'h7777_7777, 1'b0);
      #1;
      chk("unx.rvalid", 32'(rvalid), 32'd0);
      chk("unx.rdata",  rdata, 32'h0);
      chk("unx.pre",    32'(unexp), 32'd0);
      @(negedge clk);
      drive_d(1'b0, 3'd0, 8'd0, 32'h0, 1'b0);
      #1;
      chk("unx.pulse", 32'(unexp), 32'd1);
      @(negedge clk);
      #1;
      chk("unx.clear", 32'(unexp), 32'd0);

      // Source check: grants 1 then 0; second response carries source 1 instead of 0
      @(negedge clk);
      drive_req(1'b1, 1'b0, 32'h0000_0030, 4'h0, 32'h0);
      #1;
      chk("sc1.source", 32'(tl_h2d.a_source), 32'd1);
      @(negedge clk);
      #1;
      chk("sc2.source", 32'(tl_h2d.a_source), 32'd0);
      @(negedge clk);
      drive_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      drive_d(1'b1, 3'd1, 8'd1, 32'h8888_8888, 1'b0);
      #1;
      chk("sc_ok.err", 32'(err), 32'd0);
      @(negedge clk);
      drive_d(1'b1, 3'd1, 8'd1, 32'h9999_9999, 1'b0);
      #1;
      chk("sc_bad.rvalid", 32'(rvalid), 32'd1);
`ifdef TLUL_HOST_SRC_CHECK_EN
      chk("sc_bad.err", 32'(err), 32'd1);
`else
      chk("sc_bad.err", 32'(err), 32'd0);
`endif

      // Mid-transaction reset: grant one, then reset while its response is on the bus
      @(negedge clk);
      drive_d(1'b0, 3'd0, 8'd0, 32'h0, 1'b0);
      drive_req(1'b1, 1'b0, 32'h0000_0040, 4'h0, 32'h0);
      #1;
      chk("mr.gnt", 32'(gnt), 32'd1);
      @(negedge clk);
      drive_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      drive_d(1'b1, 3'd1, 8'd1, 32'hAAAA_AAAA, 1'b0);
      #1;
      chk("mr.pre_rvalid", 32'(rvalid), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("mr");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mr_post.rvalid", 32'(rvalid), 32'd0);
      @(negedge clk);
      drive_d(1'b0, 3'd0, 8'd0, 32'h0, 1'b0);
      drive_req(1'b1, 1'b0, 32'h0000_0050, 4'h0, 32'h0);
      #1;
      chk("mr_post.unexp",  32'(unexp), 32'd1);
      chk("mr_post.source", 32'(tl_h2d.a_source), 32'd0);
      chk("mr_post.gnt",    32'(gnt), 32'd1);

      @(negedge clk);
      drive_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tlul_host_adapter.md
# tlul_host_adapter

Initiator-side TL-UL bridge. It converts a simple req/gnt/rvalid memory-master interface into tlul_pkg::tl_h2d_t requests and collects tlul_pkg::tl_d2h_t responses. It is the host-end counterpart of tlul_sram_adapter. It lets simple masters (boot loader, DMA, test bus masters) drive a host port of tl_xbar_main or xbar_periph. Responses return in order, and a bounded number of transactions can be outstanding.

## Interface
Parameters:
- Outstanding, 2: maximum in-flight transactions; range 1..4; source IDs are 0..Outstanding-1.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  master request; held with its fields until gnt_o
- gnt_o  out  1  request accepted this cycle
- addr_i  in  32  byte address; bits [1:0] are ignored
- we_i  in  1  1 = write, 0 = read
- wdata_i  in  32  write data
- be_i  in  4  byte enables
- rvalid_o  out  1  response valid, one cycle per granted request, in grant order
- rdata_o  out  32  read data; 0 for writes
- err_o  out  1  response error, qualified by rvalid_o
- unexp_rsp_o  out  1  one-cycle pulse when a D-channel beat arrives with nothing outstanding
- tl_o  out  tl_h2d_t  A channel and d_ready
- tl_i  in  tl_d2h_t  D channel and a_ready

## Operation
- Outstanding counter `cnt`, width 3, reset 0:
  - +1 on an A handshake (a_valid & a_ready).
  - −1 on an accepted D beat.
  - Unchanged when both happen in the same cycle.
- a_valid = req_i & (cnt < Outstanding). It never depends on a_ready.
- gnt_o = a_valid & a_ready.
- A-channel field encoding:
  - Opcode: we_i=0 → Get (4); we_i=1 and be_i==4'hF → PutFullData (0); we_i=1 otherwise → PutPartialData (1).
  - a_size = 2, a_param = 0.
  - a_address = {addr_i[31:2], 2'b00}.
  - a_mask = 4'hF for reads, be_i for writes.
  - a_data = wdata_i for writes, 0 for reads.
  - a_user = default.
- Source ID counter `src`, reset 0:
  - Drives a_source.
  - Increments on each A handshake and wraps from Outstanding-1 to 0.
- Expected-source FIFO, depth Outstanding:
  - Pushed with a_source on the A handshake.
  - Popped on an accepted D beat.
- d_ready is constant 1.
- D beat with cnt > 0:
  - rvalid_o = 1.
  - rdata_o = d_data if d_opcode == AccessAckData, else 0.
  - err_o = d_error.
  - FIFO is popped.
- D beat with cnt == 0:
  - Beat is consumed but not forwarded: rvalid_o = 0.
  - unexp_rsp_o pulses; cnt and the FIFO are unchanged.
- Mid-operation reset: all state clears immediately. Responses that arrive after reset is released count as unexpected.

## Timing
- Reset values: gnt_o 0, rvalid_o 0, rdata_o 0, err_o 0, unexp_rsp_o 0, a_valid 0, d_ready 1.
- A channel is combinational from req_i and cnt; there is zero added latency from req_i to a_valid.
- D to response is combinational: rvalid_o is asserted in the same cycle as d_valid.
- Throughput is one grant per cycle while cnt < Outstanding.
- Full (cnt == Outstanding):
  - a_valid = 0 and gnt_o = 0.
  - If a D beat is accepted in that cycle, a_valid rises in the next cycle.
- unexp_rsp_o is registered and asserts one cycle after the offending beat.

## Configuration
- TLUL_HOST_SRC_CHECK_EN defined:
  - Each D beat's d_source is compared with the FIFO head.
  - On mismatch, err_o = 1 on that response regardless of d_error; the FIFO is still popped.
- Undefined:
  - d_source is ignored and the FIFO logic is not compiled.
  - err_o = d_error only.

## Test plan
- Single read: req_i=1, addr_i=32'h2000_0006, we_i=0, a_ready=1.
  - Required A channel: a_opcode=4, a_address=32'h2000_0004, a_mask=4'hF, a_source=0, and gnt_o in the same cycle.
  - Then d_valid, AccessAckData, d_data=32'hDEAD_BEEF → rvalid_o=1, rdata_o=32'hDEAD_BEEF, err_o=0.
- Partial write: we_i=1, be_i=4'b0011, wdata_i=32'h1234_5678.
  - Required A channel: a_opcode=1, a_mask=4'b0011, a_data=32'h1234_5678.
  - AccessAck with d_error=1 → rvalid_o=1, rdata_o=0, err_o=1.
- Backpressure, Outstanding=2: three back-to-back requests with no response.
  - Two grants, with sources 0 and 1; the third request sees a_valid=0.
  - A D beat in cycle n → a_valid=1 in cycle n+1, and the third request is granted with source 0.
- Simultaneous events: an A handshake and a D beat in the same cycle → cnt is unchanged and the FIFO stays consistent.
  - Subsequent responses return in order, with correct rvalid_o count and source order.
- Unexpected response: d_valid with cnt=0 → rvalid_o=0, and unexp_rsp_o=1 for exactly one cycle in the following cycle.
- Source check, with TLUL_HOST_SRC_CHECK_EN: expected source 0, response arrives with d_source=1 and d_error=0 → err_o=1.
  - With the macro undefined, the same stimulus gives err_o=0.
  - In both cases, assert reset mid-transaction → all outputs return to their reset values asynchronously.
